read_serializer: RTL and testbench

READ_SERIALIZER -- requirements
Module: read_serializer

---
 rtl/read_serializer.sv | 185 ++++++++++++++++++
 tb/tb_read_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_serializer.sv
// Read-side sector serializer: emits preamble, sync bit, LSB-first data words and a CRC-16,
// one bit cell per clkenbl_read_bit, as registered read_clock/read_data pulses.
module read_serializer #(
    parameter int PREAMBLE_BITS  = 128,
    parameter int WORD_COUNT     = 257,
    parameter int POSTAMBLE_BITS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clkenbl_read_bit,
    input  logic        clkenbl_read_data,
    input  logic        clock_pulse,
    input  logic        data_pulse,
    input  logic        start,
    input  logic        abort,
    output logic        mem_rd,
    output logic [8:0]  mem_addr,
    input  logic [15:0] mem_data,
    output logic        read_clock,
    output logic        read_data,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_dbg,
    output logic        data_dbg
);

    typedef enum logic [2:0] {IDLE, ARMED, PREAMBLE, SYNC, DATA, CRC, POST} state_t;

    localparam int CNT_MAX = (PREAMBLE_BITS > POSTAMBLE_BITS) ? PREAMBLE_BITS : POSTAMBLE_BITS;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int WW = $clog2(WORD_COUNT + 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE_BITS - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POSTAMBLE_BITS - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(WORD_COUNT - 1);
    localparam logic [8:0]    ADDR_LAST = 9'(WORD_COUNT - 1);

    state_t        state, state_next;
    logic [CW-1:0] cell_cnt;
    logic [3:0]    bit_cnt;
    logic [WW-1:0] word_cnt;
    logic [15:0]   shift, prefetch, crc;
    logic          cur_bit, rd_pending, data_reg;
    logic          active, finish, last_bit, last_word, word_start, fetch_first, fetch_next;

    // Reflected form of x^16+x^15+x^2+1, fed LSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {1'b0, c[15:1]} ^ ({16{c[0] ^ b}} & 16'hA001);
    endfunction

    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign data_dbg  = data_reg;

    always_comb begin
        state_next  = state;
        finish      = 1'b0;
        active      = (state != IDLE) && (state != ARMED);
        last_bit    = (bit_cnt == 4'd15);
        last_word   = (word_cnt == WORD_LAST);
        fetch_first = !abort && (state == IDLE) && start;
        word_start  = !abort && clkenbl_read_bit &&
                      ((state == SYNC) || ((state == DATA) && last_bit && !last_word));
        fetch_next  = word_start && (mem_addr != ADDR_LAST);
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     if (start) state_next = ARMED;
                ARMED:    if (clkenbl_read_bit) state_next = PREAMBLE;
                PREAMBLE: if (clkenbl_read_bit && cell_cnt == PRE_LAST) state_next = SYNC;
                SYNC:     if (clkenbl_read_bit) state_next = DATA;
                DATA:     if (clkenbl_read_bit && last_bit && last_word) state_next = CRC;
                CRC:      if (clkenbl_read_bit && last_bit) state_next = POST;
                POST: begin
                    if (clkenbl_read_bit && cell_cnt == POST_LAST) begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end
                end
                default:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_rd     <= 1'b0;
            mem_addr   <= 9'd0;
            read_clock <= 1'b0;
            read_data  <= 1'b0;
            done       <= 1'b0;
            cell_cnt   <= '0;
            bit_cnt    <= 4'd0;
            word_cnt   <= '0;
            shift      <= 16'd0;
            prefetch   <= 16'd0;
            crc        <= 16'd0;
            cur_bit    <= 1'b0;
            rd_pending <= 1'b0;
            data_reg   <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            done       <= finish;
            rd_pending <= mem_rd;
            read_clock <= clock_pulse & active & !abort;
            read_data  <= data_pulse & cur_bit & active & !abort;
            // Buffer answers one cycle after the strobe, so capture on the delayed strobe.
            if (rd_pending) prefetch <= mem_data;
            if (clkenbl_read_data && active) data_reg <= cur_bit;
            if (fetch_first) begin
                mem_rd   <= 1'b1;
                mem_addr <= 9'd0;
            end
            if (fetch_next) begin
                mem_rd   <= 1'b1;
                mem_addr <= mem_addr + 9'd1;
            end
            if (abort) begin
                cur_bit <= 1'b0;
            end else if (clkenbl_read_bit) begin
                case (state)
                    ARMED: begin
                        cur_bit  <= 1'b0;
                        cell_cnt <= '0;
                    end
                    PREAMBLE: begin
                        if (cell_cnt == PRE_LAST) begin
                            cur_bit <= 1'b1;
                            crc     <= 16'd0;
                        end else begin
                            cur_bit  <= 1'b0;
                            cell_cnt <= cell_cnt + 1'b1;
                        end
                    end
                    SYNC: begin
                        cur_bit  <= prefetch[0];
                        shift    <= {1'b0, prefetch[15:1]};
                        crc      <= crc_step(crc, prefetch[0]);
                        bit_cnt  <= 4'd0;
                        word_cnt <= '0;
                    end
                    DATA: begin
                        if (last_bit && last_word) begin
                            cur_bit <= crc[0];
                            shift   <= {1'b0, crc[15:1]};
                            bit_cnt <= 4'd0;
                        end else if (last_bit) begin
                            cur_bit  <= prefetch[0];
                            shift    <= {1'b0, prefetch[15:1]};
                            crc      <= crc_step(crc, prefetch[0]);
                            bit_cnt  <= 4'd0;
                            word_cnt <= word_cnt + 1'b1;
                        end else begin
                            cur_bit <= shift[0];
                            shift   <= {1'b0, shift[15:1]};
                            crc     <= crc_step(crc, shift[0]);
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    CRC: begin
                        if (last_bit) begin
                            cur_bit  <= 1'b0;
                            cell_cnt <= '0;
                        end else begin
                            cur_bit <= shift[0];
                            shift   <= {1'b0, shift[15:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    POST: begin
                        cur_bit  <= 1'b0;
                        cell_cnt <= cell_cnt + 1'b1;
                    end
                    default: cur_bit <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_read_serializer.sv
// Bench for read_serializer: timing generator, one-cycle-latency buffer model, stream decoder
// and a reference model building the expected cell sequence and CRC from the buffer contents.
module tb_read_serializer;

    localparam int PRE  = 128;
    localparam int WC   = 257;
    localparam int POST = 16;
    localparam int SECTOR_CELLS = PRE + 1 + WC * 16 + 16 + POST;
    localparam logic [2:0] S_IDLE = 3'd0, S_DATA = 3'd4, S_CRC = 3'd5;

    logic        clock, reset;
    logic        clkenbl_read_bit, clkenbl_read_data, clock_pulse, data_pulse;
    logic        start, abort;
    logic        mem_rd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_data;
    logic        read_clock, read_data, busy, done;
    logic [2:0]  state_dbg;
    logic        data_dbg;

    read_serializer #(.PREAMBLE_BITS(PRE), .WORD_COUNT(WC), .POSTAMBLE_BITS(POST)) dut (
        .clock(clock), .reset(reset),
        .clkenbl_read_bit(clkenbl_read_bit), .clkenbl_read_data(clkenbl_read_data),
        .clock_pulse(clock_pulse), .data_pulse(data_pulse),
        .start(start), .abort(abort),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .read_clock(read_clock), .read_data(read_data),
        .busy(busy), .done(done), .state_dbg(state_dbg), .data_dbg(data_dbg)
    );

    int checks_total = 0;
    int checks_passed = 0;

    logic [15:0] sector_buf [0:511];
    logic [0:0]  exp_q[$];
    logic [0:0]  obs_q[$];
    logic [8:0]  rd_addr_q[$];
    logic [15:0] exp_crc;
    int          data_pulses, done_cnt, cells_at_done;
    logic        mem_pend;
    logic [8:0]  mem_pend_addr;

    // Clock/reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Three-cycle bit cell: clock phase enable, clock pulse + data enable, data pulse.
    initial begin
        int phase;
        phase = 0;
        clkenbl_read_bit = 0; clkenbl_read_data = 0; clock_pulse = 0; data_pulse = 0;
        forever begin
            @(negedge clock);
            clkenbl_read_bit  = (phase == 0);
            clock_pulse       = (phase == 1);
            clkenbl_read_data = (phase == 1);
            data_pulse        = (phase == 2);
            phase = (phase == 2) ? 0 : phase + 1;
        end
    end

    // Buffer model (data valid only in the cycle after the strobe) and output decoder.
    initial begin
        mem_pend = 1'b0;
        mem_pend_addr = 9'd0;
        mem_data = 16'd0;
        forever begin
            @(negedge clock);
            mem_data = mem_pend ? sector_buf[mem_pend_addr] : 16'($urandom);
            mem_pend = mem_rd;
            mem_pend_addr = mem_addr;
            if (mem_rd) rd_addr_q.push_back(mem_addr);
            if (read_clock) obs_q.push_back(1'b0);
            if (read_data) begin
                data_pulses++;
                if (obs_q.size() > 0) obs_q[obs_q.size() - 1] = 1'b1;
            end
            if (done) begin
                done_cnt++;
                cells_at_done = obs_q.size();
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_mem_rd"}, 32'(mem_rd), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_read_clock"}, 32'(read_clock), 0);
        check({tag, "_read_data"}, 32'(read_data), 0);
        check({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
    endtask

    task automatic clear_logs();
        obs_q.delete();
        rd_addr_q.delete();
        data_pulses = 0;
        done_cnt = 0;
        cells_at_done = -1;
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_cells(input int n);
        int cyc;
        cyc = 0;
        while (obs_q.size() < n && cyc < 20000) begin
            @(posedge clock); #2;
            cyc++;
        end
        if (obs_q.size() < n) check("wait_cells_timeout", 32'(obs_q.size()), 32'(n));
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3 * SECTOR_CELLS + 200) begin
            @(posedge clock); #2;
            cyc++;
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
    endtask

    // Reference: sector layout plus word-at-a-time reflected CRC-16 starting from zero.
    task automatic build_expected();
        logic [15:0] c;
        c = 16'd0;
        exp_q.delete();
        for (int i = 0; i < PRE; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int w = 0; w < WC; w++) begin
            for (int b = 0; b < 16; b++) exp_q.push_back(sector_buf[w][b]);
            c = c ^ sector_buf[w];
            repeat (16) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        for (int b = 0; b < 16; b++) exp_q.push_back(c[b]);
        for (int i = 0; i < POST; i++) exp_q.push_back(1'b0);
        exp_crc = c;
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < 512; i++)
            sector_buf[i] = (kind == 2) ? 16'($urandom) : 16'd0;
        if (kind == 1) sector_buf[0] = 16'h0001;
    endtask

    task automatic compare_sector(input string tag);
        int first_diff, ones, bad_rd;
        logic [15:0] crc_obs;
        first_diff = -1;
        ones = 0;
        bad_rd = 0;
        crc_obs = 16'd0;
        foreach (exp_q[i]) if (exp_q[i] == 1'b1) ones++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (first_diff < 0 && obs_q[i] != exp_q[i]) first_diff = i;
        if (obs_q.size() >= PRE + 1 + WC * 16 + 16)
            for (int b = 0; b < 16; b++) crc_obs[b] = obs_q[PRE + 1 + WC * 16 + b];
        foreach (rd_addr_q[i]) if (32'(rd_addr_q[i]) != 32'(i)) bad_rd++;
        check({tag, "_cells"}, 32'(obs_q.size()), 32'(exp_q.size()));
        check({tag, "_first_diff"}, 32'(first_diff), 32'hFFFF_FFFF);
        check({tag, "_data_pulses"}, 32'(data_pulses), 32'(ones));
        check({tag, "_crc"}, 32'(crc_obs), 32'(exp_crc));
        check({tag, "_done_count"}, 32'(done_cnt), 1);
        check({tag, "_cells_at_done"}, 32'(cells_at_done), 32'(SECTOR_CELLS));
        check({tag, "_rd_count"}, 32'(rd_addr_q.size()), 32'(WC));
        check({tag, "_rd_order"}, 32'(bad_rd), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    task automatic run_sector(input string tag, input bit poke_start);
        build_expected();
        @(posedge clock); #1 clear_logs();
        repeat ($urandom_range(0, 5)) @(posedge clock);
        pulse_start();
        if (poke_start) begin
            wait_cells(10);
            pulse_start();
        end
        wait_done();
        repeat (20) @(posedge clock);
        compare_sector(tag);
    endtask

    initial begin
        int i1, i2, cells_after;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        clear_logs();
        fill(0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset_init");
        @(posedge clock); #1 reset = 1'b0;

        // start and abort together from IDLE: nothing happens
        start = 1'b1; abort = 1'b1;
        @(posedge clock); #1 start = 1'b0; abort = 1'b0;
        @(negedge clock);
        check("start_abort_busy", 32'(busy), 0);
        repeat (3) @(posedge clock);
        check("start_abort_rd", 32'(rd_addr_q.size()), 0);

        // all-zero sector: only the sync cell carries a data pulse
        fill(0);
        run_sector("zero", 1'b0);
        check("zero_total_pulses", 32'(data_pulses), 1);

        // abort mid-data at word 100, bit 7
        fill(2);
        @(posedge clock); #1 clear_logs();
        pulse_start();
        wait_cells(PRE + 1 + 100 * 16 + 7 + 1);
        check("abort_state_before", 32'(state_dbg), 32'(S_DATA));
        @(posedge clock); #1 abort = 1'b1;
        @(posedge clock); #1 abort = 1'b0;
        @(negedge clock);
        check("abort_busy", 32'(busy), 0);
        check("abort_read_clock", 32'(read_clock), 0);
        check("abort_read_data", 32'(read_data), 0);
        check("abort_mem_rd", 32'(mem_rd), 0);
        cells_after = obs_q.size();
        repeat (30) @(posedge clock);
        check("abort_no_done", 32'(done_cnt), 0);
        check("abort_no_cells", 32'(obs_q.size()), 32'(cells_after));

        // fresh sector after abort: word 0 = 1
        fill(1);
        run_sector("word0", 1'b0);
        i1 = -1; i2 = -1;
        foreach (obs_q[i]) if (obs_q[i] == 1'b1) begin
            if (i1 < 0) i1 = i;
            else if (i2 < 0) i2 = i;
        end
        check("word0_sync_cell", 32'(i1), 32'(PRE));
        check("word0_bit0_cell", 32'(i2), 32'(PRE + 1));

        // random data, with a start poked while busy
        fill(2);
        run_sector("random", 1'b1);

        // reset during the CRC field, with start held through reset
        fill(2);
        @(posedge clock); #1 clear_logs();
        pulse_start();
        wait_cells(PRE + 1 + WC * 16 + 5);
        check("reset_mid_state", 32'(state_dbg), 32'(S_CRC));
        @(posedge clock); #1 reset = 1'b1; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset_mid");
        @(posedge clock); #1 reset = 1'b0; start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("reset_start_ignored", 32'(busy), 0);
        check("reset_no_done", 32'(done_cnt), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
